// File: rtl/fp32_pkg.sv
// Shared FP32 types and constants for the multiplier arbiter slice.
package fp32_pkg;
  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_ONE  = 32'h3F80_0000;
  localparam fp32_t FP32_PINF = 32'h7F80_0000;
endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO of requester tags with first-word fall-through output.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/fp32_mul_arbiter.sv
// Round-robin sharing of one pipelined FP32 multiplier; results routed back by queued tag.
module fp32_mul_arbiter
  import fp32_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_data,
  output logic                  mul_valid_in,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic                  mul_valid_out,
  input  logic [31:0]           mul_out,
  output logic                  busy,
  output logic                  err_underflow
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic             accept;
  logic             pop;
  logic [IDX_W-1:0] tag_head;
  logic [CNT_W-1:0] out_count;
  fp32_t            sel_a;
  fp32_t            sel_b;

  // Scan from the lowest priority upward so the last hit is the highest priority.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  // A full tag FIFO blocks issue even when a pop lands in the same cycle.
  assign accept    = rstn && grant_any && (out_count < CNT_W'(MAX_OUTSTANDING));
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign sel_a     = req_a[grant_idx*32 +: 32];
  assign sel_b     = req_b[grant_idx*32 +: 32];
  assign pop       = mul_valid_out && (out_count != '0);
  assign busy      = (out_count != '0);

  tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (accept),
    .pop   (pop),
    .din   (grant_idx),
    .dout  (tag_head),
    .count (out_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr        <= '0;
      mul_valid_in  <= 1'b0;
      mul_a         <= FP32_ZERO;
      mul_b         <= FP32_ZERO;
      resp_valid    <= '0;
      resp_data     <= FP32_ZERO;
      err_underflow <= 1'b0;
    end else begin
      mul_valid_in <= accept;
      if (accept) begin
        mul_a  <= sel_a;
        mul_b  <= sel_b;
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
      resp_valid <= '0;
      if (pop) begin
        resp_valid <= NUM_REQ'(1) << tag_head;
        resp_data  <= mul_out;
      end
      if (mul_valid_out && (out_count == '0)) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Bench for fp32_mul_arbiter: two instances (depth 8 and depth 2) with behavioural multipliers.
module tb_fp32_mul_arbiter;
  import fp32_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int PD      = MUL_LAT + 1;  // model registers its inputs, then MUL_LAT stages
  localparam int EXP_LAT = MUL_LAT + 2;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic         clk, rstn, inj;
  logic [3:0]   rv0, rv1, rdy0, rdy1, resv0, resv1;
  logic [127:0] ra0, rb0, ra1, rb1;
  logic [31:0]  rd0, rd1, ma0, mb0, ma1, mb1, mout0, mout1;
  logic         mvin0, mvin1, mvout0, mvout1, busy0, busy1, err0, err1;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  sb_t sb0[$];
  sb_t sb1[$];

  logic        vp0 [PD];
  logic        vp1 [PD];
  logic [31:0] dp0 [PD];
  logic [31:0] dp1 [PD];

  fp32_mul_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(8)) u_dut (
    .clk(clk), .rstn(rstn), .req_valid(rv0), .req_a(ra0), .req_b(rb0), .req_ready(rdy0),
    .resp_valid(resv0), .resp_data(rd0), .mul_valid_in(mvin0), .mul_a(ma0), .mul_b(mb0),
    .mul_valid_out(mvout0), .mul_out(mout0), .busy(busy0), .err_underflow(err0));

  fp32_mul_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(2)) u_cap (
    .clk(clk), .rstn(rstn), .req_valid(rv1), .req_a(ra1), .req_b(rb1), .req_ready(rdy1),
    .resp_valid(resv1), .resp_data(rd1), .mul_valid_in(mvin1), .mul_a(ma1), .mul_b(mb1),
    .mul_valid_out(mvout1), .mul_out(mout1), .busy(busy1), .err_underflow(err1));

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb, m;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return 32'h7FC0_0000;
    if (ea == 8'hFF || eb == 8'hFF) begin
      if (ea == 8'h00 || eb == 8'h00) return 32'h7FC0_0000;
      return {s, 8'hFF, 23'h0};
    end
    if (ea == 8'h00 || eb == 8'h00) return {s, 31'h0};
    p = {1'b1, fa} * {1'b1, fb};
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], m};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PD; i++) begin
        vp0[i] <= 1'b0;
        vp1[i] <= 1'b0;
      end
    end else begin
      vp0[0] <= mvin0; dp0[0] <= fp_mul(ma0, mb0);
      vp1[0] <= mvin1; dp1[0] <= fp_mul(ma1, mb1);
      for (int i = 1; i < PD; i++) begin
        vp0[i] <= vp0[i-1]; dp0[i] <= dp0[i-1];
        vp1[i] <= vp1[i-1]; dp1[i] <= dp1[i-1];
      end
    end
  end

  assign mvout0 = vp0[PD-1] | inj;
  assign mout0  = dp0[PD-1];
  assign mvout1 = vp1[PD-1];
  assign mout1  = dp1[PD-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int u, input logic [3:0] rv, input logic [3:0] rdy,
                     input logic [127:0] a, input logic [127:0] b,
                     input logic [3:0] resv, input logic [31:0] rd);
    sb_t e;
    int  n;
    n = (u == 0) ? sb0.size() : sb1.size();
    if (resv != 0) begin
      if (n == 0) begin
        fail_now($sformatf("unexpected_resp_u%0d", u));
      end else begin
        if (u == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        check($sformatf("resp_route_u%0d", u), {28'h0, resv}, {28'h0, 4'b0001 << e.idx});
        check($sformatf("resp_data_u%0d", u), rd, e.data);
        check($sformatf("resp_latency_u%0d", u), 32'(cyc - e.cyc - 1), 32'(EXP_LAT));
      end
    end
    if ((rdy & ~rv) != 0) check($sformatf("ready_without_valid_u%0d", u), {28'h0, rdy}, {28'h0, rdy & rv});
    for (int i = 0; i < 4; i++) begin
      if (rv[i] && rdy[i]) begin
        e.idx  = i;
        e.data = fp_mul(a[i*32 +: 32], b[i*32 +: 32]);
        e.cyc  = cyc;
        if (u == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      sb0.delete();
      sb1.delete();
    end else begin
      mon(0, rv0, rdy0, ra0, rb0, resv0, rd0);
      mon(1, rv1, rdy1, ra1, rb1, resv1, rd1);
    end
  end

  task automatic do_single(input int idx, input logic [31:0] a, input logic [31:0] b,
                           output logic [3:0] gv, output logic [31:0] gd);
    int n;
    tick();
    rv0 = 4'b0001 << idx;
    ra0[idx*32 +: 32] = a;
    rb0[idx*32 +: 32] = b;
    @(negedge clk);
    n = 0;
    while (!rdy0[idx] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("single_accept");
    tick();
    rv0 = '0;
    gv = '0;
    gd = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (resv0 != 0) begin
        gv = resv0;
        gd = rd0;
        break;
      end
    end
    if (gv == 0) fail_now("single_resp");
  endtask

  task automatic apply_reset(input int n);
    tick();
    rstn = 1'b0;
    repeat (n) tick();
    rstn = 1'b1;
  endtask

  vec_t        vecs[6];
  logic [3:0]  gv;
  logic [31:0] gd;
  int          grants[4];
  int          n;

  initial begin
    vecs[0] = '{0, FP32_ONE,     32'h4000_0000, 32'h4000_0000};
    vecs[1] = '{3, 32'h4080_0000, FP32_ONE,     32'h4080_0000};
    vecs[2] = '{1, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000};
    vecs[3] = '{2, FP32_ZERO,    FP32_PINF,     32'h7FC0_0000};
    vecs[4] = '{1, 32'hBF80_0000, 32'h4040_0000, 32'hC040_0000};
    vecs[5] = '{3, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000};

    rstn = 1'b0; inj = 1'b0;
    rv0 = 4'b1111; rv1 = '0;
    ra0 = {4{FP32_ONE}}; rb0 = {4{FP32_ONE}}; ra1 = '0; rb1 = '0;
    #2;
    check("rst_req_ready", {28'h0, rdy0}, 32'h0);
    check("rst_mul_valid_in", {31'h0, mvin0}, 32'h0);
    check("rst_mul_a", ma0, 32'h0);
    check("rst_resp_valid", {28'h0, resv0}, 32'h0);
    check("rst_resp_data", rd0, 32'h0);
    check("rst_busy_err", {30'h0, busy0, err0}, 32'h0);
    rv0 = '0;
    repeat (3) tick();
    rstn = 1'b1;

    foreach (vecs[i]) begin
      do_single(vecs[i].idx, vecs[i].a, vecs[i].b, gv, gd);
      check($sformatf("vec%0d_route", i), {28'h0, gv}, {28'h0, 4'b0001 << vecs[i].idx});
      check($sformatf("vec%0d_data", i), gd, vecs[i].exp);
    end

    tick();
    rv0 = 4'b1000; ra0[96 +: 32] = 32'h4080_0000; rb0[96 +: 32] = FP32_ONE;
    @(negedge clk);
    check("route_ready3", {28'h0, rdy0}, 32'h8);
    tick();
    rv0 = 4'b0010; ra0[32 +: 32] = 32'h4040_0000; rb0[32 +: 32] = 32'h4000_0000;
    @(negedge clk);
    check("route_ready1", {28'h0, rdy0}, 32'h2);
    tick();
    rv0 = '0;
    n = 0;
    while (resv0 == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("route_resp");
    check("route_first_valid", {28'h0, resv0}, 32'h8);
    check("route_first_data", rd0, 32'h4080_0000);
    @(negedge clk);
    check("route_second_valid", {28'h0, resv0}, 32'h2);
    check("route_second_data", rd0, 32'h40C0_0000);
    repeat (10) tick();

    apply_reset(2);
    tick();
    for (int i = 0; i < 4; i++) grants[i] = 0;
    rv0 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      ra0[i*32 +: 32] = FP32_ONE;
      rb0[i*32 +: 32] = 32'h4000_0000 + (i << 23);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check($sformatf("fair_grant_%0d", k), {28'h0, rdy0}, {28'h0, 4'b0001 << (k % 4)});
      for (int i = 0; i < 4; i++) if (rdy0[i]) grants[i]++;
    end
    tick();
    rv0 = '0;
    for (int i = 0; i < 4; i++) check($sformatf("fair_count_%0d", i), grants[i], 32'd10);
    repeat (12) tick();

    rv1 = 4'b0001; ra1[31:0] = 32'h4040_0000; rb1[31:0] = 32'h4040_0000;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      check($sformatf("cap_ready_%0d", j), {31'h0, rdy1[0]}, {31'h0, (j % 6) < 2});
      check($sformatf("cap_busy_%0d", j), {31'h0, busy1}, {31'h0, j >= 1});
    end
    tick();
    rv1 = '0;
    repeat (12) tick();

    rv0 = 4'b0111;
    repeat (3) tick();
    rstn = 1'b0;
    #1;
    check("midrst_ready", {28'h0, rdy0}, 32'h0);
    check("midrst_mul", {31'h0, mvin0}, 32'h0);
    check("midrst_mul_ab", ma0 | mb0, 32'h0);
    check("midrst_resp", {28'h0, resv0}, 32'h0);
    check("midrst_data", rd0, 32'h0);
    check("midrst_busy", {31'h0, busy0}, 32'h0);
    rv0 = '0;
    repeat (2) tick();
    rstn = 1'b1;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (resv0 != 0) n++;
    end
    check("midrst_no_resp", n, 32'h0);
    do_single(2, 32'h4040_0000, 32'h4040_0000, gv, gd);
    check("postrst_route", {28'h0, gv}, 32'h4);
    check("postrst_data", gd, 32'h4110_0000);
    repeat (10) tick();

    check("uf_before", {31'h0, err0}, 32'h0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    @(negedge clk);
    check("uf_set", {31'h0, err0}, 32'h1);
    check("uf_no_resp", {28'h0, resv0}, 32'h0);
    repeat (5) tick();
    @(negedge clk);
    check("uf_sticky", {31'h0, err0}, 32'h1);
    check("uf_not_busy", {31'h0, busy0}, 32'h0);

    check("sb0_drained", sb0.size(), 32'h0);
    check("sb1_drained", sb1.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
